// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative round sequencer.
package aes_seq_pkg;

   localparam int unsigned BLK_W = 128;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned LAT_W = 3;

   localparam logic [BLK_W-1:0] DEFAULT_SEED = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/aes_seq_ctrl.sv
// Sequencer FSM with round and latency counters; emits load enables for the
// accumulator held in the top level.
module aes_seq_ctrl
   import aes_seq_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 20,
   parameter int unsigned ROUND_LAT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             rnd_go,
   output logic             busy,
   output logic             acc_ld_key,
   output logic             acc_ld_res,
   output logic [CNT_W-1:0] rnd_cnt
);

   seq_state_t       state, state_nx;
   logic [LAT_W-1:0] lat_cnt;
   logic             accept, capture, last_round;

   assign accept     = (state == IDLE) && in_valid;
   assign capture    = (state == WAIT) && (lat_cnt == LAT_W'(ROUND_LAT));
   assign last_round = (rnd_cnt == CNT_W'(NUM_ROUNDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // rnd_cnt reaches NUM_ROUNDS in DONE and is cleared only on the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         if (accept)       rnd_cnt <= '0;
         else if (capture) rnd_cnt <= rnd_cnt + CNT_W'(1);

         if (state == ISSUE)                  lat_cnt <= LAT_W'(1);
         else if (state == WAIT && !capture)  lat_cnt <= lat_cnt + LAT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (capture) state_nx = last_round ? DONE : ISSUE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      rnd_go     = 1'b0;
      busy       = 1'b1;
      acc_ld_key = 1'b0;
      acc_ld_res = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready   = 1'b1;
            busy       = 1'b0;
            acc_ld_key = accept;
         end
         ISSUE:   rnd_go     = 1'b1;
         WAIT:    acc_ld_res = capture;
         DONE:    out_valid  = 1'b1;
         default: busy       = 1'b0;
      endcase
   end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative round sequencer: whitens the job key, loops it NUM_ROUNDS times
// through an external registered round datapath, and returns the result.
module aes_round_sequencer
   import aes_seq_pkg::*;
#(
   parameter int unsigned      NUM_ROUNDS = 20,
   parameter int unsigned      ROUND_LAT  = 1,
   parameter logic [BLK_W-1:0] SEED_CONST = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic [BLK_W-1:0] rnd_state_o,
   output logic [BLK_W-1:0] rnd_key_o,
   output logic             rnd_go_o,
   input  logic [BLK_W-1:0] rnd_result_i,
   output logic             busy,
   output logic [CNT_W-1:0] round_idx
);

   logic [BLK_W-1:0] acc;
   logic             acc_ld_key, acc_ld_res;

   aes_seq_ctrl #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .ROUND_LAT  (ROUND_LAT)
   ) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .rnd_go     (rnd_go_o),
      .busy       (busy),
      .acc_ld_key (acc_ld_key),
      .acc_ld_res (acc_ld_res),
      .rnd_cnt    (round_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          acc <= '0;
      else if (acc_ld_key) acc <= in_key ^ SEED_CONST;
      else if (acc_ld_res) acc <= rnd_result_i;
   end

   // acc only changes on accept or capture, so it is stable throughout DONE.
   assign out_data    = acc;
   assign rnd_key_o   = acc;
   assign rnd_state_o = SEED_CONST;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using a stub datapath (registered key+1).
module tb_aes_round_sequencer;

   localparam logic [127:0] SEED   = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;
   localparam logic [127:0] EXP_K0 = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa1e;
   localparam logic [127:0] EXP_K2 = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa1c;
   localparam logic [127:0] EXP_K1 = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa1f;
   localparam logic [127:0] EXP_U1 = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0b;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         in_valid0, in_ready0, out_valid0, out_ready0, go0, busy0;
   logic [127:0] key0, data0, st0, rkey0, res0;
   logic [7:0]   idx0;

   logic         in_valid1, in_ready1, out_valid1, out_ready1, go1, busy1;
   logic [127:0] key1, data1, st1, rkey1, res1;
   logic [7:0]   idx1;

   aes_round_sequencer u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_key(key0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(data0), .rnd_state_o(st0),
      .rnd_key_o(rkey0), .rnd_go_o(go0), .rnd_result_i(res0), .busy(busy0), .round_idx(idx0)
   );

   aes_round_sequencer #(.NUM_ROUNDS(1), .ROUND_LAT(3)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_key(key1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(data1), .rnd_state_o(st1),
      .rnd_key_o(rkey1), .rnd_go_o(go1), .rnd_result_i(res1), .busy(busy1), .round_idx(idx1)
   );

   always @(posedge clk) begin
      res0 <= rkey0 + 128'd1;
      res1 <= rkey1 + 128'd1;
   end

   int acc_cnt0 = 0, go_cnt0 = 0, go_cnt1 = 0, viol0 = 0;
   always @(negedge clk) begin
      if (in_valid0 && in_ready0) acc_cnt0++;
      if (in_ready0 && busy0)     viol0++;
      if (go0)                    go_cnt0++;
      if (go1)                    go_cnt1++;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one job on u0 from IDLE, wait for DONE, check latency/data, then handshake.
   task automatic run_job0(input logic [127:0] k, input logic [127:0] exp, input string tag);
      int n;
      in_valid0 = 1'b1;
      key0      = k;
      step();
      in_valid0 = 1'b0;
      n = 1;
      while (!out_valid0 && n < 200) begin
         step();
         n++;
      end
      check({tag, "_lat"}, 128'(n), 128'd41);
      check({tag, "_data"}, data0, exp);
      out_ready0 = 1'b1;
      step();
      out_ready0 = 1'b0;
      check({tag, "_idle"}, 128'(out_valid0), 128'd0);
   endtask

   initial begin
      int n, base_acc, base_go;
      rst_n = 1'b0;
      in_valid0 = 1'b0; out_ready0 = 1'b0; key0 = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; key1 = '0;
      step();
      step();
      check("rst_in_ready",  128'(in_ready0),  128'd1);
      check("rst_out_valid", 128'(out_valid0), 128'd0);
      check("rst_go",        128'(go0),        128'd0);
      check("rst_busy",      128'(busy0),      128'd0);
      check("rst_idx",       128'(idx0),       128'd0);
      check("rst_data",      data0,            128'd0);
      check("rst_state_op",  st0,              SEED);
      rst_n = 1'b1;
      step();

      // Scenario 1: key 0, first two rounds by hand then latency and result.
      in_valid0 = 1'b1;
      key0      = '0;
      step();
      in_valid0 = 1'b0;
      check("t1_go_c1",    128'(go0),       128'd1);
      check("t1_key_c1",   rkey0,           SEED);
      check("t1_busy_c1",  128'(busy0),     128'd1);
      check("t1_ready_c1", 128'(in_ready0), 128'd0);
      step();
      check("t1_go_c2",    128'(go0),       128'd0);
      check("t1_idx_c2",   128'(idx0),      128'd0);
      step();
      check("t1_go_c3",    128'(go0),       128'd1);
      check("t1_idx_c3",   128'(idx0),      128'd1);
      check("t1_key_c3",   rkey0,           SEED + 128'd1);
      n = 3;
      while (!out_valid0 && n < 200) begin
         step();
         n++;
      end
      check("t1_lat",      128'(n),         128'd41);
      check("t1_data",     data0,           EXP_K0);
      check("t1_idx_done", 128'(idx0),      128'd20);

      // Scenario 3: backpressure with a second request pending.
      in_valid0 = 1'b1;
      key0      = 128'd2;
      base_acc  = acc_cnt0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_hold_valid", 128'(out_valid0), 128'd1);
         check("t3_hold_data",  data0,            EXP_K0);
         check("t3_hold_ready", 128'(in_ready0),  128'd0);
      end
      out_ready0 = 1'b1;
      check("t3_done_ready", 128'(in_ready0), 128'd0);
      step();
      out_ready0 = 1'b0;
      check("t3_idle_ready", 128'(in_ready0),  128'd1);
      check("t3_idle_valid", 128'(out_valid0), 128'd0);
      check("t3_no_acc",     128'(acc_cnt0),   128'(base_acc));
      step();
      in_valid0 = 1'b0;
      check("t3_acc_once",   128'(acc_cnt0),   128'(base_acc + 1));
      check("t3_busy",       128'(busy0),      128'd1);
      n = 1;
      while (!out_valid0 && n < 200) begin
         step();
         n++;
      end
      check("t3_lat",  128'(n), 128'd41);
      check("t3_data", data0,   EXP_K2);
      out_ready0 = 1'b1;
      step();
      out_ready0 = 1'b0;

      // Scenario 4: asynchronous reset mid-job at round 7.
      in_valid0 = 1'b1;
      key0      = '0;
      step();
      in_valid0 = 1'b0;
      n = 0;
      while (idx0 != 8'd7 && n < 100) begin
         step();
         n++;
      end
      check("t4_reach_r7", 128'(idx0), 128'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_rst_ready", 128'(in_ready0),  128'd1);
      check("t4_rst_valid", 128'(out_valid0), 128'd0);
      check("t4_rst_go",    128'(go0),        128'd0);
      check("t4_rst_busy",  128'(busy0),      128'd0);
      check("t4_rst_idx",   128'(idx0),       128'd0);
      check("t4_rst_data",  data0,            128'd0);
      step();
      #2;
      rst_n = 1'b1;
      step();
      check("t4_post_busy",  128'(busy0),     128'd0);
      check("t4_post_ready", 128'(in_ready0), 128'd1);
      run_job0(128'd0, EXP_K0, "t4_job");

      // Scenario 5: single round with 3-cycle datapath latency.
      base_go   = go_cnt1;
      in_valid1 = 1'b1;
      key1      = '0;
      step();
      in_valid1 = 1'b0;
      n = 1;
      while (!out_valid1 && n < 50) begin
         step();
         n++;
      end
      check("t5_lat",  128'(n),                 128'd5);
      check("t5_data", data1,                   EXP_U1);
      check("t5_go",   128'(go_cnt1 - base_go), 128'd1);
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      check("t5_idle", 128'(out_valid1), 128'd0);

      // Scenario 6: in_valid held high across three back-to-back jobs.
      base_acc   = acc_cnt0;
      base_go    = go_cnt0;
      in_valid0  = 1'b1;
      key0       = 128'd1;
      out_ready0 = 1'b1;
      for (int i = 0; i < 101; i++) step();
      in_valid0 = 1'b0;
      n = 0;
      while (!out_valid0 && n < 100) begin
         step();
         n++;
      end
      check("t6_data", data0, EXP_K1);
      step();
      out_ready0 = 1'b0;
      check("t6_idle",    128'(busy0),               128'd0);
      check("t6_accepts", 128'(acc_cnt0 - base_acc), 128'd3);
      check("t6_gos",     128'(go_cnt0 - base_go),   128'd60);
      check("t6_viol",    128'(viol0),               128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
